// File: rtl/fifo_pkg.sv
// Shared sizing constants and the data word type for the synchronous FIFO.
package fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one write port, one read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read is captured by the top's data_out register, which needs an
  // async reset the storage array itself must not have.
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with active-low strobes and registered over/under-flow
// boundary flags; pointers, count, flags and accept logic live here.
module sync_fifo_core
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    fill_count,
  output logic             over_flow,
  output logic             under_flow
);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HIGH = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LOW  = CW'(1);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] rd_word;

  // A write at full is still accepted when a read frees a slot on the same
  // edge; a read at empty never bypasses the write.
  assign rd_acc = !read_n && (count != '0);
  assign wr_acc = !write_n && ((count < CNT_FULL) || rd_acc);

  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign fill_count = count;

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      over_flow  <= 1'b0;
      under_flow <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PW'(1);
        data_out <= rd_word;
      end
      count <= count + CW'(wr_acc) - CW'(rd_acc);

      if (rd_acc)                             over_flow <= 1'b0;
      else if (!write_n && count >= CNT_HIGH) over_flow <= 1'b1;

      if (wr_acc)                            under_flow <= 1'b0;
      else if (!read_n && count <= CNT_LOW)  under_flow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed bench for sync_fifo_core with a queue scoreboard of expected read data.
module tb_sync_fifo_core;
  import fifo_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             write_n, read_n;
  fifo_word_t       data_in;
  fifo_word_t       data_out;
  logic             full, empty, over_flow, under_flow;
  logic [CNT_W-1:0] fill_count;

  int vectors = 0;
  int errs    = 0;

  fifo_word_t sb_q[$];
  fifo_word_t exp_dout;
  logic       exp_of, exp_uf;

  sync_fifo_core #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .write_n    (write_n),
    .read_n     (read_n),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .fill_count (fill_count),
    .over_flow  (over_flow),
    .under_flow (under_flow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".fill_count"}, 32'(fill_count), 32'(sb_q.size()));
    chk({tag, ".full"},       32'(full),       32'(sb_q.size() == FIFO_DEPTH));
    chk({tag, ".empty"},      32'(empty),      32'(sb_q.size() == 0));
    chk({tag, ".data_out"},   32'(data_out),   32'(exp_dout));
    chk({tag, ".over_flow"},  32'(over_flow),  32'(exp_of));
    chk({tag, ".under_flow"}, 32'(under_flow), 32'(exp_uf));
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_dout = '0;
    exp_of   = 1'b0;
    exp_uf   = 1'b0;
  endtask

  // One clock: drive strobes on the falling edge, predict, check after the rising edge.
  task automatic cycle(input bit wr, input bit rd, input fifo_word_t din, input string tag);
    int  sz;
    bit  racc, wacc;
    @(negedge clock);
    write_n = ~wr;
    read_n  = ~rd;
    data_in = din;
    sz   = sb_q.size();
    racc = rd && (sz > 0);
    wacc = wr && ((sz < FIFO_DEPTH) || racc);
    if (racc)                              exp_of = 1'b0;
    else if (wr && sz >= FIFO_DEPTH - 1)   exp_of = 1'b1;
    if (wacc)                              exp_uf = 1'b0;
    else if (rd && sz <= 1)                exp_uf = 1'b1;
    if (racc) exp_dout = sb_q.pop_front();
    if (wacc) sb_q.push_back(din);
    @(posedge clock);
    #1;
    chk_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    write_n = 1'b1;
    read_n  = 1'b1;
    data_in = '0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, "idle");
    cycle(1'b0, 1'b1, 8'h00, "first_read_empty");
    chk("first_read_uf", 32'(under_flow), 32'd1);
    chk("first_read_dout", 32'(data_out), 32'h00);

    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, fifo_word_t'(i), "fill");
    chk("fill_count16", 32'(fill_count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_of", 32'(over_flow), 32'd1);
    cycle(1'b1, 1'b0, 8'hAA, "drop_write");
    chk("drop_count", 32'(fill_count), 32'd16);

    cycle(1'b1, 1'b1, 8'h55, "rw_at_full");
    chk("rw_full_count", 32'(fill_count), 32'd16);
    chk("rw_full_of", 32'(over_flow), 32'd0);
    chk("rw_full_dout", 32'(data_out), 32'h00);

    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, "drain");
    chk("drain_last", 32'(data_out), 32'h55);
    chk("drain_uf", 32'(under_flow), 32'd1);
    chk("drain_empty", 32'(empty), 32'd1);

    cycle(1'b1, 1'b1, 8'h77, "rw_at_empty");
    chk("rw_empty_count", 32'(fill_count), 32'd1);
    chk("rw_empty_uf", 32'(under_flow), 32'd0);
    chk("rw_empty_dout", 32'(data_out), 32'h55);
    cycle(1'b0, 1'b1, 8'h00, "read_77");
    chk("read_77", 32'(data_out), 32'h77);

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, fifo_word_t'(8'h10 + i), "wrap_w10");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, "wrap_r10");
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, fifo_word_t'(8'h40 + i), "wrap_w12");
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 8'h00, "wrap_r12");
      chk("wrap_order", 32'(data_out), 32'(8'h40 + i));
    end
    chk("wrap_count0", 32'(fill_count), 32'd0);

    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, fifo_word_t'(8'hC0 + i), "pre_reset");
    cycle(1'b0, 1'b1, 8'h00, "pre_reset_read");
    cycle(1'b1, 1'b0, 8'hC7, "pre_reset_w");
    chk("pre_reset_count", 32'(fill_count), 32'd7);
    #2;
    write_n = 1'b1;
    read_n  = 1'b1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h99, "post_reset_w");
    cycle(1'b0, 1'b1, 8'h00, "post_reset_r");
    chk("post_reset_data", 32'(data_out), 32'h99);
    chk("post_reset_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
